// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl
//   Frequency-setpoint controller for the DDS source, clocked on clk_50m.
//   NORM mode steps freq with the up/down keys along a fine (+/-1) then
//   coarse (COARSE_STEP) ladder. LEARN mode steps freq by LEARN_STEP on each
//   next_freq rise. SWEEP mode steps freq by LEARN_STEP every DWELL cycles.
//   The NORM setpoint is saved on learn entry and restored on exit.
//
// Ports
//   clk_50m    in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_n[1:0] in   async buttons, active-low; [0]=down, [1]=up
//   learn_en   in   async level; rise enters LEARN/SWEEP, fall returns to NORM
//   auto_sweep in   async level, sampled at learn entry (1=SWEEP, 0=LEARN)
//   next_freq  in   async; each rising edge is one LEARN step
//   freq       out  current setpoint, units of 100 Hz
//   pinc       out  registered DDS phase increment, freq*10 + ((freq+2)>>2)
//   freq_upd   out  one-cycle pulse in the cycle pinc takes a new value
//   mode       out  FSM state: 01=NORM, 10=LEARN, 11=SWEEP
//   sweep_done out  LEARN/SWEEP has reached LEARN_MAX
//
// pinc is consumed in the DDS clock domain and only changes together with
// freq_upd. Each input edge is seen once and freq moves at most once per
// edge or dwell period, so pinc holds for >=3 cycles when DWELL>=3 and input
// edges are at least 3 cycles apart.
module freq_sweep_ctrl #(
  parameter int FREQ_W      = 16,
  parameter int PINC_W      = 24,
  parameter int FREQ_MIN    = 1,
  parameter int FINE_MAX    = 30,
  parameter int COARSE_STEP = 1500,
  parameter int FREQ_MAX    = 4500,
  parameter int LEARN_START = 10,
  parameter int LEARN_STEP  = 2,
  parameter int LEARN_MAX   = 4500,
  parameter int DWELL       = 50000000
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [1:0]        key_n,
  input  logic              learn_en,
  input  logic              auto_sweep,
  input  logic              next_freq,
  output logic [FREQ_W-1:0] freq,
  output logic [PINC_W-1:0] pinc,
  output logic              freq_upd,
  output logic [1:0]        mode,
  output logic              sweep_done
);

  typedef enum logic [1:0] {
    MODE_ILLEGAL = 2'b00,
    MODE_NORM    = 2'b01,
    MODE_LEARN   = 2'b10,
    MODE_SWEEP   = 2'b11
  } mode_e;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [FREQ_W-1:0] F_MIN    = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] F_FINE   = FREQ_W'(FINE_MAX);
  localparam logic [FREQ_W-1:0] F_COARSE = FREQ_W'(COARSE_STEP);
  localparam logic [FREQ_W-1:0] F_MAX    = FREQ_W'(FREQ_MAX);
  localparam logic [FREQ_W-1:0] L_START  = FREQ_W'(LEARN_START);
  localparam logic [FREQ_W-1:0] L_MAX    = FREQ_W'(LEARN_MAX);
  localparam logic [PINC_W-1:0] PINC_RST = PINC_W'(FREQ_MIN * 10 + (FREQ_MIN + 2) / 4);
  // Idle levels of the synchronisers: keys released (high), levels low.
  // Bit map: 0=down key, 1=up key, 2=learn_en, 3=auto_sweep, 4=next_freq.
  localparam logic [4:0]        SYNC_RST = 5'b00011;

  logic [4:0] in_raw;
  logic [4:0] sync1_d, sync1_q, sync2_d, sync2_q, hist_d, hist_q;

  mode_e             mode_d, mode_q;
  logic [FREQ_W-1:0] freq_d, freq_q, freq_save_d, freq_save_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [PINC_W-1:0] pinc_d, pinc_q, freq_ext;
  logic              freq_upd_d, freq_upd_q;
  logic              done_d, done_q;

  logic              down_press, up_press, learn_rise, learn_fall, next_rise;
  logic [FREQ_W:0]   learn_sum;
  logic [FREQ_W-1:0] learn_next, up_next, down_next;

  assign in_raw = {next_freq, auto_sweep, learn_en, key_n};

  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Keys are active-low, so a press is a falling edge of the synced level.
  assign down_press = hist_q[0] & ~sync2_q[0];
  assign up_press   = hist_q[1] & ~sync2_q[1];
  assign learn_rise = ~hist_q[2] & sync2_q[2];
  assign learn_fall = hist_q[2] & ~sync2_q[2];
  assign next_rise  = ~hist_q[4] & sync2_q[4];

  // One extra bit so the saturation compare cannot wrap.
  assign learn_sum  = {1'b0, freq_q} + (FREQ_W + 1)'(LEARN_STEP);
  assign learn_next = (learn_sum >= (FREQ_W + 1)'(LEARN_MAX)) ? L_MAX : learn_sum[FREQ_W-1:0];

  always_comb begin
    up_next = freq_q + F_COARSE;
    if (freq_q < F_FINE)       up_next = freq_q + FREQ_W'(1);
    else if (freq_q == F_FINE) up_next = F_COARSE;
    else if (freq_q >= F_MAX)  up_next = freq_q;
  end

  always_comb begin
    down_next = freq_q - F_COARSE;
    if (freq_q == F_MIN)         down_next = F_FINE;
    else if (freq_q <= F_FINE)   down_next = freq_q - FREQ_W'(1);
    else if (freq_q == F_COARSE) down_next = F_FINE;
  end

  always_comb begin
    mode_d      = mode_q;
    freq_d      = freq_q;
    freq_save_d = freq_save_q;
    cnt_d       = cnt_q;
    case (mode_q)
      MODE_NORM: begin
        // Learn entry takes priority; a key press in the same cycle is dropped.
        if (learn_rise) begin
          freq_save_d = freq_q;
          freq_d      = L_START;
          mode_d      = sync2_q[3] ? MODE_SWEEP : MODE_LEARN;
          cnt_d       = '0;
        end else if (down_press) begin
          freq_d = down_next;
        end else if (up_press) begin
          freq_d = up_next;
        end
      end
      MODE_LEARN: begin
        if (learn_fall) begin
          freq_d = freq_save_q;
          mode_d = MODE_NORM;
          cnt_d  = '0;
        end else if (next_rise) begin
          freq_d = learn_next;
        end
      end
      MODE_SWEEP: begin
        if (learn_fall) begin
          freq_d = freq_save_q;
          mode_d = MODE_NORM;
          cnt_d  = '0;
        end else if (freq_q < L_MAX) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            freq_d = learn_next;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        mode_d = MODE_NORM;
        freq_d = F_MIN;
        cnt_d  = '0;
      end
    endcase
    done_d = (mode_d == MODE_LEARN || mode_d == MODE_SWEEP) && (freq_d == L_MAX);
  end

  assign freq_ext   = PINC_W'(freq_q);
  assign pinc_d     = freq_ext * PINC_W'(10) + ((freq_ext + PINC_W'(2)) >> 2);
  assign freq_upd_d = (pinc_d != pinc_q);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      hist_q      <= SYNC_RST;
      mode_q      <= MODE_NORM;
      freq_q      <= F_MIN;
      freq_save_q <= F_MIN;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      pinc_q      <= PINC_RST;
      freq_upd_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      mode_q      <= mode_d;
      freq_q      <= freq_d;
      freq_save_q <= freq_save_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      pinc_q      <= pinc_d;
      freq_upd_q  <= freq_upd_d;
    end
  end

  assign freq       = freq_q;
  assign pinc       = pinc_q;
  assign freq_upd   = freq_upd_q;
  assign mode       = mode_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl with a short dwell (DWELL=4) and a low learn
// ceiling (LEARN_MAX=20). A behavioural model reacts to each input edge
// three clocks after the pin changes and tracks NORM steps as moves along
// an explicit ladder of legal setpoints.
module tb_freq_sweep_ctrl;

  localparam int FREQ_W      = 16;
  localparam int PINC_W      = 24;
  localparam int FREQ_MIN    = 1;
  localparam int FINE_MAX    = 30;
  localparam int COARSE_STEP = 1500;
  localparam int FREQ_MAX    = 4500;
  localparam int LEARN_START = 10;
  localparam int LEARN_STEP  = 2;
  localparam int LEARN_MAX   = 20;
  localparam int DWELL       = 4;

  // clock / reset
  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic [1:0]        key_n      = 2'b11;
  logic              learn_en   = 1'b0;
  logic              auto_sweep = 1'b0;
  logic              next_freq  = 1'b0;
  logic [FREQ_W-1:0] freq;
  logic [PINC_W-1:0] pinc;
  logic              freq_upd;
  logic [1:0]        mode;
  logic              sweep_done;

  freq_sweep_ctrl #(
    .FREQ_W(FREQ_W), .PINC_W(PINC_W), .FREQ_MIN(FREQ_MIN), .FINE_MAX(FINE_MAX),
    .COARSE_STEP(COARSE_STEP), .FREQ_MAX(FREQ_MAX), .LEARN_START(LEARN_START),
    .LEARN_STEP(LEARN_STEP), .LEARN_MAX(LEARN_MAX), .DWELL(DWELL)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .key_n(key_n), .learn_en(learn_en),
    .auto_sweep(auto_sweep), .next_freq(next_freq), .freq(freq), .pinc(pinc),
    .freq_upd(freq_upd), .mode(mode), .sweep_done(sweep_done)
  );

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // behavioural model
  int ladder[$];
  int m_freq, m_save, m_mode, m_tick, m_pinc;
  bit m_done, m_upd;
  logic [4:0] h1, h2, h3;  // pin samples 1, 2 and 3 edges ago
  logic [PINC_W-1:0] exp_q[$];

  function automatic int pinc_of(input int f);
    return f * 10 + (f + 2) / 4;
  endfunction

  function automatic int ladder_pos(input int f);
    foreach (ladder[i]) if (ladder[i] == f) return i;
    return -1;
  endfunction

  function automatic int ladder_up(input int f);
    int i = ladder_pos(f);
    if (i < 0 || i == ladder.size() - 1) return f;
    return ladder[i + 1];
  endfunction

  function automatic int ladder_down(input int f);
    int i = ladder_pos(f);
    if (i < 0) return f;
    if (i == 0) return FINE_MAX;
    return ladder[i - 1];
  endfunction

  function automatic int learn_step(input int f);
    return (f + LEARN_STEP > LEARN_MAX) ? LEARN_MAX : f + LEARN_STEP;
  endfunction

  task automatic model_reset();
    m_freq = FREQ_MIN; m_save = FREQ_MIN; m_mode = 1; m_tick = 0;
    m_done = 1'b0; m_upd = 1'b0; m_pinc = pinc_of(FREQ_MIN);
    h1 = 5'b00011; h2 = 5'b00011; h3 = 5'b00011;
    exp_q.delete();
  endtask

  task automatic model_step();
    int  np;
    bit  dn, up, lr, lf, nr;
    np = pinc_of(m_freq);
    m_upd = (np != m_pinc);
    m_pinc = np;
    if (m_upd) exp_q.push_back(PINC_W'(np));
    dn = h3[0] & ~h2[0];
    up = h3[1] & ~h2[1];
    lr = ~h3[2] & h2[2];
    lf = h3[2] & ~h2[2];
    nr = ~h3[4] & h2[4];
    if (m_mode == 1) begin
      if (lr) begin
        m_save = m_freq; m_freq = LEARN_START; m_tick = 0;
        m_mode = h2[3] ? 3 : 2;
      end else if (dn) m_freq = ladder_down(m_freq);
      else if (up) m_freq = ladder_up(m_freq);
    end else if (lf) begin
      m_freq = m_save; m_mode = 1; m_tick = 0;
    end else if (m_mode == 2) begin
      if (nr) m_freq = learn_step(m_freq);
    end else if (m_freq < LEARN_MAX) begin
      m_tick++;
      if (m_tick == DWELL) begin
        m_tick = 0;
        m_freq = learn_step(m_freq);
      end
    end
    m_done = (m_mode != 1) && (m_freq == LEARN_MAX);
    h3 = h2; h2 = h1; h1 = {next_freq, auto_sweep, learn_en, key_n};
  endtask

  initial begin
    for (int f = FREQ_MIN; f <= FINE_MAX; f++) ladder.push_back(f);
    for (int f = COARSE_STEP; f <= FREQ_MAX; f += COARSE_STEP) ladder.push_back(f);
    model_reset();
    forever begin
      @(posedge clk_50m or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // scoreboard / per-cycle compare
  initial begin
    forever begin
      @(negedge clk_50m);
      chk("freq", freq, m_freq);
      chk("pinc", pinc, m_pinc);
      chk("freq_upd", freq_upd, m_upd);
      chk("mode", mode, m_mode);
      chk("sweep_done", sweep_done, m_done);
      if (freq_upd) begin
        upd_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_pinc: got %0d with no expected update queued", pinc);
        end else begin
          chk("sb_pinc", pinc, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic press(input logic [1:0] mask, input int hold);
    @(negedge clk_50m);
    key_n = ~mask;
    cycles(hold);
    key_n = 2'b11;
    cycles(4);
  endtask

  task automatic pulse_next(input int hold);
    @(negedge clk_50m);
    next_freq = 1'b1;
    cycles(hold);
    next_freq = 1'b0;
    cycles(3);
  endtask

  task automatic set_learn(input logic lvl, input logic as);
    @(negedge clk_50m);
    auto_sweep = as;
    learn_en = lvl;
    cycles(5);
  endtask

  task automatic wait_freq(input int val, input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_50m);
      if (freq == val) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL wait_freq_%0d: freq %0d, target not reached in %0d cycles", val, freq, budget);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, u0;
    logic [1:0] mask;
    cycles(4);
    rst_n = 1'b1;
    cycles(3);
    chk("t1_freq", freq, 1);
    chk("t1_pinc", pinc, 10);
    chk("t1_mode", mode, 1);
    chk("t1_done", sweep_done, 0);
    chk("t1_upd", freq_upd, 0);
    chk("t1_model_pinc", m_pinc, 10);

    repeat (29) press(2'b10, 2);
    chk("t2_freq30", freq, 30);
    chk("t2_model30", m_freq, 30);
    press(2'b10, 2); chk("t2_freq1500", freq, 1500);
    press(2'b10, 2); chk("t2_freq3000", freq, 3000);
    press(2'b10, 2); chk("t2_freq4500", freq, 4500);
    chk("t2_pinc4500", pinc, 46125);
    chk("t2_model_pinc", m_pinc, 46125);
    u0 = upd_seen;
    press(2'b10, 2);
    chk("t2_hold4500", freq, 4500);
    chk("t2_no_upd", upd_seen - u0, 0);

    press(2'b01, 2); chk("t3_down3000", freq, 3000);
    press(2'b11, 2); chk("t3_both1500", freq, 1500);
    press(2'b01, 2); chk("t3_down1500_to30", freq, 30);
    repeat (29) press(2'b01, 2);
    chk("t3_down_to1", freq, 1);
    press(2'b01, 2); chk("t3_wrap30", freq, 30);
    chk("t3_model_wrap", m_freq, 30);
    u0 = upd_seen;
    press(2'b10, 60);
    chk("t3_held_single", freq, 1500);
    chk("t3_held_one_upd", upd_seen - u0, 1);

    set_learn(1'b1, 1'b0);
    chk("t4_learn_freq", freq, 10);
    chk("t4_learn_mode", mode, 2);
    repeat (3) pulse_next(3);
    chk("t4_freq16", freq, 16);
    chk("t4_model16", m_freq, 16);
    set_learn(1'b0, 1'b0);
    chk("t4_restore", freq, 1500);
    chk("t4_mode_norm", mode, 1);

    @(negedge clk_50m);
    auto_sweep = 1'b1;
    learn_en = 1'b1;
    wait_freq(10, 10, n);
    wait_freq(20, 40, n);
    chk("t5_dwell_cycles", n, 20);
    cycles(10);
    chk("t5_hold20", freq, 20);
    chk("t5_done", sweep_done, 1);
    chk("t5_mode_sweep", mode, 3);
    set_learn(1'b0, 1'b1);
    chk("t5_restore", freq, 1500);

    // exit lands on the same edge as the 14->16 step
    @(negedge clk_50m);
    learn_en = 1'b1;
    wait_freq(14, 20, n);
    @(negedge clk_50m);
    learn_en = 1'b0;
    cycles(6);
    chk("t6_exit_freq", freq, 1500);
    chk("t6_exit_mode", mode, 1);
    chk("t6_exit_done", sweep_done, 0);

    @(negedge clk_50m);
    learn_en = 1'b1;
    wait_freq(14, 20, n);
    @(negedge clk_50m);
    rst_n = 1'b0;
    learn_en = 1'b0;
    #1;
    chk("t6_rst_freq", freq, 1);
    chk("t6_rst_pinc", pinc, 10);
    chk("t6_rst_mode", mode, 1);
    chk("t6_rst_done", sweep_done, 0);
    chk("t6_rst_upd", freq_upd, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    chk("t6_after_rst", freq, 1);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: begin
          mask = 2'($urandom_range(1, 3));
          press(mask, $urandom_range(1, 4));
        end
        3: pulse_next($urandom_range(1, 3));
        4: begin
          @(negedge clk_50m);
          auto_sweep = 1'($urandom_range(0, 1));
          learn_en = ~learn_en;
          cycles($urandom_range(1, 6));
        end
        5: begin
          @(negedge clk_50m);
          learn_en = ~learn_en;
          key_n = ~2'($urandom_range(1, 3));
          cycles(1);
          key_n = 2'b11;
          cycles(3);
        end
        6: cycles($urandom_range(1, 20));
        default: begin
          @(negedge clk_50m);
          auto_sweep = 1'($urandom_range(0, 1));
          next_freq = 1'b1;
          key_n = ~2'($urandom_range(0, 3));
          cycles($urandom_range(1, 3));
          next_freq = 1'b0;
          key_n = 2'b11;
          cycles(2);
        end
      endcase
    end
    @(negedge clk_50m);
    learn_en = 1'b0;
    cycles(10);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
